// File: rtl/stage_mem_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | stage_mem_pkg : shared widths, word typedefs and loader FSM encoding   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package stage_mem_pkg;

  localparam int STAGE_DATA = 64;
  localparam int STAGE_ADDR = 11;

  typedef logic [STAGE_DATA-1:0] stage_word_t;
  typedef logic [STAGE_ADDR-1:0] stage_addr_t;
  typedef logic [STAGE_ADDR:0]   stage_len_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_FIN    = 2'd3
  } stage_state_e;

endpackage
`default_nettype wire

// File: rtl/stage_mem_shadow.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | stage_mem_shadow : copy of written words for read-back compare        |
// | Built only with STAGE_MEM_LOADER_READBACK_EN.  Rev 1.0                 |
// +-----------------------------------------------------------------------+
`ifdef STAGE_MEM_LOADER_READBACK_EN
module stage_mem_shadow
  import stage_mem_pkg::*;
#(
  parameter int DATA = STAGE_DATA,
  parameter int ADDR = STAGE_ADDR
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [ADDR-1:0] wr_addr,
  input  logic [DATA-1:0] wr_data,
  input  logic            rd_en,
  input  logic [ADDR-1:0] rd_addr,
  output logic [DATA-1:0] rd_data
);

  // Indexed by RAM address: every address of a command is written once.
  logic [DATA-1:0] mem_q [2**ADDR];
  logic [DATA-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule
`endif
`default_nettype wire

// File: rtl/stage_mem_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | stage_mem_loader : streams (base,len) commands into a stage table RAM  |
// | Optional read-back: STAGE_MEM_LOADER_READBACK_EN.  Rev 1.0             |
// +-----------------------------------------------------------------------+
module stage_mem_loader
  import stage_mem_pkg::*;
#(
  parameter int DATA = STAGE_DATA,
  parameter int ADDR = STAGE_ADDR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [ADDR-1:0] cmd_base,
  input  logic [ADDR:0]   cmd_len,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DATA-1:0] s_data,
  output logic            mem_wr,
  output logic [ADDR-1:0] mem_addr,
  output logic [DATA-1:0] mem_din,
  input  logic [DATA-1:0] mem_dout,
  output logic            busy,
  output logic            done,
  output logic            mismatch
);

  localparam logic [ADDR-1:0] ADDR_STEP = ADDR'(1);
  localparam logic [ADDR:0]   LEN_STEP  = (ADDR+1)'(1);

  stage_state_e    state_q, state_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [ADDR:0]   rem_q, rem_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            s_ready_q, s_ready_d;
  logic            mem_wr_q, mem_wr_d;
  logic [ADDR-1:0] mem_addr_q, mem_addr_d;
  logic [DATA-1:0] mem_din_q, mem_din_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            cmd_hs, s_hs;

  assign cmd_hs = cmd_valid && cmd_ready_q;
  assign s_hs   = s_valid && s_ready_q;

`ifdef STAGE_MEM_LOADER_READBACK_EN
  logic [ADDR-1:0] base_q, base_d;
  logic [ADDR:0]   len_q, len_d;
  logic            rd1_q, rd1_d, rd2_q, rd2_d;
  logic            mismatch_q, mismatch_d;
  logic [DATA-1:0] sh_rdata;

  stage_mem_shadow #(.DATA(DATA), .ADDR(ADDR)) u_shadow (
    .clk     (clk),
    .wr_en   (s_hs),
    .wr_addr (addr_q),
    .wr_data (s_data),
    .rd_en   (rd1_q),
    .rd_addr (mem_addr_q),
    .rd_data (sh_rdata)
  );
`else
  logic unused_dout;
  assign unused_dout = ^mem_dout;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    cmd_ready_d = 1'b0;
    s_ready_d   = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    busy_d      = 1'b1;
    done_d      = 1'b0;
`ifdef STAGE_MEM_LOADER_READBACK_EN
    base_d      = base_q;
    len_d       = len_q;
    rd1_d       = 1'b0;
    rd2_d       = 1'b0;
    mismatch_d  = mismatch_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // cmd_ready is still low in the done cycle, so no command lands there.
        cmd_ready_d = !cmd_hs;
        busy_d      = cmd_hs;
        if (cmd_hs) begin
          addr_d = cmd_base;
          rem_d  = cmd_len;
`ifdef STAGE_MEM_LOADER_READBACK_EN
          base_d     = cmd_base;
          len_d      = cmd_len;
          mismatch_d = 1'b0;
`endif
          if (cmd_len == '0) begin
            state_d = ST_FIN;
          end else begin
            state_d   = ST_LOAD;
            s_ready_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        s_ready_d = 1'b1;
        if (s_hs) begin
          mem_wr_d   = 1'b1;
          mem_addr_d = addr_q;
          mem_din_d  = s_data;
          addr_d     = addr_q + ADDR_STEP;
          rem_d      = rem_q - LEN_STEP;
          if (rem_q == LEN_STEP) begin
            s_ready_d = 1'b0;
`ifdef STAGE_MEM_LOADER_READBACK_EN
            state_d = ST_VERIFY;
            addr_d  = base_q;
            rem_d   = len_q;
`else
            state_d = ST_FIN;
`endif
          end
        end
      end
`ifdef STAGE_MEM_LOADER_READBACK_EN
      ST_VERIFY: begin
        // rd1: read address on the port; rd2: RAM and shadow data both valid.
        rd2_d = rd1_q;
        if (rem_q != '0) begin
          mem_addr_d = addr_q;
          addr_d     = addr_q + ADDR_STEP;
          rem_d      = rem_q - LEN_STEP;
          rd1_d      = 1'b1;
        end
        if (rd2_q && (mem_dout != sh_rdata)) mismatch_d = 1'b1;
        if ((rem_q == '0) && !rd1_q && rd2_q) state_d = ST_FIN;
      end
`endif
      ST_FIN: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      cmd_ready_q <= 1'b1;
      s_ready_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      cmd_ready_q <= cmd_ready_d;
      s_ready_q   <= s_ready_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef STAGE_MEM_LOADER_READBACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q     <= '0;
      len_q      <= '0;
      rd1_q      <= 1'b0;
      rd2_q      <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      base_q     <= base_d;
      len_q      <= len_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch = mismatch_q;
`else
  assign mismatch = 1'b0;
`endif

  assign cmd_ready = cmd_ready_q;
  assign s_ready   = s_ready_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
`default_nettype wire
